// File: rtl/puf_seq_ctrl_if.sv
// puf_seq_ctrl_if: request/response valid-ready handshake between host logic and the PUF sequencer
interface puf_seq_ctrl_if #(
  parameter int CHAL_W = 32,
  parameter int RESP_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [CHAL_W-1:0] req_chal;
  logic [1:0]        req_sel;
  logic [1:0]        req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RESP_W-1:0] rsp_data;
  logic              rsp_so;
  modport master (
    output req_valid, req_chal, req_sel, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_so
  );
  modport slave (
    input  req_valid, req_chal, req_sel, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_so
  );
endinterface

// File: rtl/puf_seq_ctrl.sv
// puf_seq_ctrl: loads a challenge into the PUF chain, resets and evaluates it, then shifts out the response
module puf_seq_ctrl #(
  parameter int CHAL_W   = 32,
  parameter int RESP_W   = 16,
  parameter int EVAL_CYC = 8,
  parameter int RST_CYC  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  puf_seq_ctrl_if.slave    bus,
  output logic             busy,
  output logic             puf_reset,
  output logic [1:0]       puf_sel,
  output logic [1:0]       puf_length,
  output logic             puf_si,
  output logic             puf_rstn,
  output logic             puf_clk_en,
  input  logic             puf_out,
  input  logic             puf_so
);
  localparam int EMAX = EVAL_CYC << 3;
  localparam int M1   = CHAL_W > RESP_W ? CHAL_W : RESP_W;
  localparam int MAXC = M1 > EMAX ? M1 : EMAX;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, LOAD, ARM, EVAL, CAPT, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CHAL_W-1:0] chal;
  logic accept, abort_hit, last;
  always_comb begin
    accept    = bus.req_valid && bus.req_ready;
    abort_hit = abort && state != IDLE;
    last      = (state == LOAD) ? cnt == CW'(CHAL_W - 1) :
                (state == ARM)  ? cnt == CW'(RST_CYC - 1) :
                (state == EVAL) ? cnt == CW'((EVAL_CYC << puf_length) - 1) :
                (state == CAPT) ? cnt == CW'(RESP_W - 1) : 1'b0;
    state_n   = abort_hit ? IDLE :
                (state == IDLE) ? (accept ? LOAD : IDLE) :
                (state == DONE) ? ((bus.rsp_valid && bus.rsp_ready) ? IDLE : DONE) :
                last ? state_t'(state + 3'd1) : state;
    cnt_n     = (state_n != state || state == IDLE || state == DONE) ? '0 : cnt + 1'b1;
  end
  // Outputs are registered from next-state values so they line up with the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      chal          <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_so    <= 1'b0;
      busy          <= 1'b0;
      puf_reset     <= 1'b1;
      puf_sel       <= '0;
      puf_length    <= '0;
      puf_si        <= 1'b0;
      puf_rstn      <= 1'b0;
      puf_clk_en    <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      chal          <= accept ? bus.req_chal << 1 : (state == LOAD) ? chal << 1 : chal;
      puf_sel       <= accept ? bus.req_sel : puf_sel;
      puf_length    <= accept ? bus.req_len : puf_length;
      puf_si        <= (state_n == LOAD) && (accept ? bus.req_chal[CHAL_W-1] : chal[CHAL_W-1]);
      puf_clk_en    <= state_n == LOAD || state_n == CAPT;
      puf_rstn      <= state_n != ARM;
      puf_reset     <= abort_hit;
      busy          <= state_n != IDLE;
      // One idle cycle after leaving DONE or aborting before a new request is taken
      bus.req_ready <= state == IDLE && state_n == IDLE;
      bus.rsp_valid <= state_n == DONE;
      bus.rsp_so    <= (state == LOAD && last) ? puf_so : bus.rsp_so;
      bus.rsp_data  <= (state == CAPT && !abort_hit) ? {bus.rsp_data[RESP_W-2:0], puf_out} : bus.rsp_data;
    end
  end
endmodule
